// File: rtl/div_uint_seq.sv
// div_uint_seq: sequential restoring unsigned divider, one quotient bit per clock.
// Operands are accepted on an in_valid/in_ready handshake. The result is held
// until it leaves on an out_valid/out_ready handshake. Operations do not overlap.
module div_uint_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_rem;   // partial remainder; always < divisor, so WIDTH bits hold it
  logic [WIDTH-1:0] r_dq;    // dividend bits shift out the top while quotient bits shift in at the bottom
  logic [WIDTH-1:0] r_div;   // latched divisor
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic             r_dz;

  logic [WIDTH:0]   w_t;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_dq_nxt;

  // One restoring step: the trial subtraction is done at WIDTH+1 bits and its
  // borrow bit doubles as the t >= B compare.
  always_comb begin
    w_t       = {r_rem, r_dq[WIDTH-1]};
    w_diff    = w_t - {1'b0, r_div};
    w_ge      = ~w_diff[WIDTH];
    w_rem_nxt = w_ge ? w_diff[WIDTH-1:0] : w_t[WIDTH-1:0];
    w_dq_nxt  = {r_dq[WIDTH-2:0], w_ge};
  end

  // Control FSM plus datapath registers; result registers only move on entry to DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_rem       <= '0;
      r_dq        <= '0;
      r_div       <= '0;
      r_cnt       <= '0;
      r_q         <= '0;
      r_r         <= '0;
      r_dz        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_div      <= B;
            r_in_ready <= 1'b0;
            if (B == '0) begin
              // Divide by zero skips the iteration entirely.
              r_q         <= '1;
              r_r         <= A;
              r_dz        <= 1'b1;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_rem   <= '0;
              r_dq    <= A;
              r_cnt   <= CW'(WIDTH - 1);
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          r_rem <= w_rem_nxt;
          r_dq  <= w_dq_nxt;
          if (r_cnt == '0) begin
            r_q         <= w_dq_nxt;
            r_r         <= w_rem_nxt;
            r_dz        <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_DONE: begin
          // in_ready comes back one cycle after the output handshake.
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign Q           = r_q;
  assign R           = r_r;
  assign div_by_zero = r_dz;

endmodule

// File: tb/tb_div_uint_seq.sv
// tb_div_uint_seq: directed table plus corner sequences for a WIDTH=4 divider,
// and a randomized invariant sweep for a WIDTH=8 divider.
module tb_div_uint_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=4 instance
  logic       iv4 = 1'b0, ir4, ov4, or4 = 1'b0, dz4;
  logic [3:0] a4 = '0, b4 = '0, q4, r4;
  // WIDTH=8 instance
  logic       iv8 = 1'b0, ir8, ov8, or8 = 1'b0, dz8;
  logic [7:0] a8 = '0, b8 = '0, q8, r8;

  div_uint_seq #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .A(a4), .B(b4),
    .out_valid(ov4), .out_ready(or4), .Q(q4), .R(r4), .div_by_zero(dz4));

  div_uint_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .A(a8), .B(b8),
    .out_valid(ov8), .out_ready(or8), .Q(q8), .R(r8), .div_by_zero(dz8));

  int n_chk = 0;
  int n_err = 0;

  // Last result each DUT should be showing (bench-side expectation).
  logic [3:0] pq4 = '0, pr4 = '0;
  logic       pdz4 = 1'b0;
  logic [7:0] pq8 = '0, pr8 = '0;
  logic       pdz8 = 1'b0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] q;
    logic [3:0] r;
    logic       dz;
    int         lat;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // One full WIDTH=4 transaction with expected values supplied by the caller.
  task automatic op4(input string nm, input logic [3:0] a, input logic [3:0] b,
                     input logic [3:0] eq, input logic [3:0] er, input logic edz,
                     input int elat, input int stall, input bit tog);
    int lat;
    @(negedge clk);
    chk({nm, " in_ready before"}, 32'(ir4), 32'd1);
    iv4 = 1'b1; a4 = a; b4 = b;
    @(negedge clk);
    iv4 = 1'b0; a4 = ~a; b4 = ~b;   // operand changes after acceptance must not matter
    lat = 1;
    while (!ov4 && lat < 40) begin
      chk({nm, " run hold"}, {ir4, q4, r4, dz4}, {1'b0, pq4, pr4, pdz4});
      @(negedge clk);
      lat++;
    end
    chk({nm, " latency"}, 32'(lat), 32'(elat));
    chk({nm, " Q"}, 32'(q4), 32'(eq));
    chk({nm, " R"}, 32'(r4), 32'(er));
    chk({nm, " dz"}, 32'(dz4), 32'(edz));
    chk({nm, " in_ready busy"}, 32'(ir4), 32'd0);
    for (int i = 0; i < stall; i++) begin
      if (tog) begin
        iv4 = 1'($urandom); a4 = 4'($urandom); b4 = 4'($urandom);
      end
      @(negedge clk);
      chk({nm, " stall hold"}, {ov4, ir4, q4, r4, dz4}, {1'b1, 1'b0, eq, er, edz});
    end
    iv4 = 1'b0; or4 = 1'b1;
    @(negedge clk);
    or4 = 1'b0;
    chk({nm, " after handshake"}, {ov4, ir4, q4, r4, dz4}, {1'b0, 1'b1, eq, er, edz});
    pq4 = eq; pr4 = er; pdz4 = edz;
  endtask

  // One WIDTH=8 transaction checked against floor/mod and the Q*B+R invariant.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input int stall);
    int lat;
    logic [7:0] eq, er;
    logic edz;
    edz = (b == 8'd0);
    eq  = edz ? 8'hFF : a / b;
    er  = edz ? a : a % b;
    @(negedge clk);
    chk("w8 in_ready before", 32'(ir8), 32'd1);
    iv8 = 1'b1; a8 = a; b8 = b;
    @(negedge clk);
    iv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    lat = 1;
    while (!ov8 && lat < 60) begin
      chk("w8 run hold", {ir8, q8, r8, dz8}, {1'b0, pq8, pr8, pdz8});
      @(negedge clk);
      lat++;
    end
    chk("w8 latency", 32'(lat), edz ? 32'd1 : 32'd9);
    chk("w8 Q", 32'(q8), 32'(eq));
    chk("w8 R", 32'(r8), 32'(er));
    chk("w8 dz", 32'(dz8), 32'(edz));
    if (!edz) begin
      chk("w8 Q*B+R", 32'(q8) * 32'(b) + 32'(r8), 32'(a));
      chk("w8 R<B", 32'(r8 < b), 32'd1);
    end
    repeat (stall) begin
      @(negedge clk);
      chk("w8 stall hold", {ov8, q8, r8, dz8}, {1'b1, eq, er, edz});
    end
    or8 = 1'b1;
    @(negedge clk);
    or8 = 1'b0;
    chk("w8 after handshake", {ov8, ir8}, {1'b0, 1'b1});
    pq8 = eq; pr8 = er; pdz8 = edz;
  endtask

  initial begin
    int quiet_bad;
    tbl[0] = '{4'd13, 4'd3,  4'd4,  4'd1, 1'b0, 5};
    tbl[1] = '{4'd7,  4'd0,  4'd15, 4'd7, 1'b1, 1};
    tbl[2] = '{4'd15, 4'd1,  4'd15, 4'd0, 1'b0, 5};
    tbl[3] = '{4'd0,  4'd5,  4'd0,  4'd0, 1'b0, 5};
    tbl[4] = '{4'd3,  4'd9,  4'd0,  4'd3, 1'b0, 5};
    tbl[5] = '{4'd6,  4'd6,  4'd1,  4'd0, 1'b0, 5};
    tbl[6] = '{4'd9,  4'd2,  4'd4,  4'd1, 1'b0, 5};
    tbl[7] = '{4'd0,  4'd0,  4'd15, 4'd0, 1'b1, 1};
    tbl[8] = '{4'd15, 4'd15, 4'd1,  4'd0, 1'b0, 5};
    tbl[9] = '{4'd11, 4'd4,  4'd2,  4'd3, 1'b0, 5};

    // Reset state
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("reset w4", {ir4, ov4, q4, r4, dz4}, {1'b1, 1'b0, 4'd0, 4'd0, 1'b0});
    chk("reset w8", {ir8, ov8, q8, r8, dz8}, {1'b1, 1'b0, 8'd0, 8'd0, 1'b0});

    // Directed table
    for (int i = 0; i < 10; i++)
      op4($sformatf("vec%0d %0d/%0d", i, tbl[i].a, tbl[i].b), tbl[i].a, tbl[i].b,
          tbl[i].q, tbl[i].r, tbl[i].dz, tbl[i].lat, 0, 1'b0);

    // Backpressure: 10 stalled cycles with input noise, then one handshake
    op4("bp 2/9", 4'd2, 4'd9, 4'd0, 4'd2, 1'b0, 5, 10, 1'b1);

    // Put a nonzero result up so the reset clear is visible
    op4("pre-reset 13/3", 4'd13, 4'd3, 4'd4, 4'd1, 1'b0, 5, 0, 1'b0);

    // Reset during the second RUN cycle of 14/5
    @(negedge clk);
    iv4 = 1'b1; a4 = 4'd14; b4 = 4'd5;
    @(negedge clk);            // accepted
    iv4 = 1'b0;
    @(negedge clk);            // first RUN edge done
    rst_n = 1'b0;
    @(negedge clk);            // reset applied on second RUN edge
    rst_n = 1'b1;
    chk("mid-run reset", {ov4, ir4, q4, r4, dz4}, {1'b0, 1'b1, 4'd0, 4'd0, 1'b0});
    pq4 = '0; pr4 = '0; pdz4 = 1'b0;
    pq8 = '0; pr8 = '0; pdz8 = 1'b0;
    quiet_bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (ov4) quiet_bad++;
    end
    chk("no output after reset", 32'(quiet_bad), 32'd0);
    op4("post-reset 14/5", 4'd14, 4'd5, 4'd2, 4'd4, 1'b0, 5, 0, 1'b0);

    // Exhaustive WIDTH=4 sweep with random output stalls
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        if (b == 0)
          op4($sformatf("sw %0d/0", a), 4'(a), 4'd0, 4'hF, 4'(a), 1'b1, 1,
              int'($urandom_range(0, 2)), 1'b0);
        else
          op4($sformatf("sw %0d/%0d", a, b), 4'(a), 4'(b), 4'(a / b), 4'(a % b), 1'b0, 5,
              int'($urandom_range(0, 2)), 1'b0);
      end
    end

    // WIDTH=8 random sampling, plus a few fixed corners
    op8(8'd0, 8'd7, 0);
    op8(8'd255, 8'd1, 1);
    op8(8'd200, 8'd0, 0);
    op8(8'd77, 8'd77, 0);
    op8(8'd5, 8'd250, 2);
    for (int i = 0; i < 256; i++)
      op8(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
